// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: shared matrix geometry, FSM and frame-classification types
package keypad_scanner_pkg;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;
    localparam int KEYS   = ROWS * COLS;
    typedef enum logic {RELEASED, HELD} state_t;
    typedef enum logic [1:0] {EMPTY, SINGLE, MULTI} class_t;
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key matrix lines plus key event outputs
interface keypad_scanner_if;
    import keypad_scanner_pkg::*;
    logic [ROWS-1:0]   key_row;
    logic [COLS-1:0]   key_col;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_down;
    modport master (input key_row, output key_col, key_valid, key_code, key_down);
    modport slave  (output key_row, input key_col, key_valid, key_code, key_down);
endinterface

// File: rtl/keypad_scanner_debounce.sv
// keypad_debounce: classifies whole frames, debounces them and tracks press/release
module keypad_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEYS-1:0]   frame,
    input  logic              frame_done,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_down
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    state_t            state, state_nxt;
    class_t            cls, cand_cls, cand_cls_nxt;
    logic [CODE_W-1:0] code, cand_code, cand_code_nxt, key_code_nxt;
    logic [CNT_W-1:0]  count, count_nxt, sat;
    logic              same, hit, key_valid_nxt;

    assign key_down = (state == HELD);

    // classify the frame: empty, one key (with its bit index) or a ghost-prone multi-press
    always_comb begin
        code = '0;
        for (int i = 0; i < KEYS; i++)
            if (frame[i]) code = CODE_W'(i);
        cls = (frame == '0) ? EMPTY : $onehot(frame) ? SINGLE : MULTI;
    end

    // debounce counting and press/release decisions; events fire only when the count first saturates
    always_comb begin
        state_nxt     = state;
        cand_cls_nxt  = cand_cls;
        cand_code_nxt = cand_code;
        count_nxt     = count;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        same = (cls == cand_cls) && (code == cand_code);
        sat  = !same ? CNT_W'(1) : (count == CNT_MAX) ? count : count + CNT_W'(1);
        hit  = frame_done && (cls != MULTI) && (sat == CNT_MAX) && !(same && count == CNT_MAX);
        if (frame_done) begin
            cand_cls_nxt  = cls;
            cand_code_nxt = code;
            count_nxt     = (cls == MULTI) ? '0 : sat;
        end
        if (hit && cls == SINGLE && (state == RELEASED || code != key_code)) begin
            state_nxt     = HELD;
            key_code_nxt  = code;
            key_valid_nxt = 1'b1;
        end
        if (hit && cls == EMPTY) state_nxt = RELEASED;
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RELEASED;
            cand_cls  <= EMPTY;
            cand_code <= '0;
            count     <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand_cls  <= cand_cls_nxt;
            cand_code <= cand_code_nxt;
            count     <= count_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes columns on a divided tick, samples rows into 16-key frames
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic               clk,
    input logic               rst,
    keypad_scanner_if.master  kif
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [KEYS-1:0]  frame;
    logic             frame_done;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // divider, column strobe and row sampling; the sample uses the rows seen under the old column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            col_idx     <= '0;
            frame       <= '0;
            frame_done  <= 1'b0;
            kif.key_col <= 4'b1110;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
            frame_done <= tick && (col_idx == 2'd3);
            if (tick) begin
                frame[{col_idx, 2'b00} +: ROWS] <= ~kif.key_row;
                col_idx     <= col_idx + 2'd1;
                kif.key_col <= ~(COLS'(1) << (col_idx + 2'd1));
            end
        end
    end

    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame),
        .frame_done(frame_done),
        .key_valid (kif.key_valid),
        .key_code  (kif.key_code),
        .key_down  (kif.key_down)
    );
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios against a modelled 4x4 key matrix
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = '0;
    int          k, pulses, last_pulse, errors, checks;
    bit          col_bad;

    keypad_scanner_if kif();

    function automatic logic [3:0] rows_of(input logic [3:0] col, input logic [15:0] p);
        logic [3:0] r;
        r = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                if (!col[c] && p[c*4+rr]) r[rr] = 1'b0;
        return r;
    endfunction

    assign kif.key_row = rows_of(kif.key_col, pressed);

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        logic [3:0] one, exp;
        one = 4'b0001;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            exp = ~(one << ((k / 4) % 4));
            if (kif.key_col !== exp) col_bad = 1'b1;
            if (kif.key_valid === 1'b1) begin
                pulses++;
                last_pulse = k;
            end
        end
    endtask

    task automatic frame(input logic [15:0] p);
        pressed = p;
        step(16);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pressed = '0;
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        pulses = 0;
        last_pulse = -1;
        col_bad = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (kif.key_col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b exp=1110", kif.key_col); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", kif.key_valid); end
        checks++; if (kif.key_code !== 4'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", kif.key_code); end
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL reset_down got=%b exp=0", kif.key_down); end
        rst = 1'b0;
        k = 0; pulses = 0; last_pulse = -1; col_bad = 1'b0;
    endtask

    task automatic test_idle();
        step(4);
        checks++; if (kif.key_col !== 4'b1101) begin errors++; $display("FAIL idle_col4 got=%b exp=1101", kif.key_col); end
        step(60);
        checks++; if (col_bad) begin errors++; $display("FAIL idle_col_seq got=bad exp=rotating one-cold"); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_pulses got=%0d exp=0", pulses); end
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL idle_down got=%b exp=0", kif.key_down); end
    endtask

    task automatic test_hold();
        do_reset();
        repeat (6) frame(16'h0200);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses got=%0d exp=1", pulses); end
        checks++; if (last_pulse !== 49) begin errors++; $display("FAIL hold_pulse_cycle got=%0d exp=49", last_pulse); end
        checks++; if (kif.key_code !== 4'd9) begin errors++; $display("FAIL hold_code got=%0d exp=9", kif.key_code); end
        checks++; if (kif.key_down !== 1'b1) begin errors++; $display("FAIL hold_down got=%b exp=1", kif.key_down); end
    endtask

    task automatic test_release();
        repeat (3) frame(16'h0000);
        checks++; if (kif.key_down !== 1'b1) begin errors++; $display("FAIL release_down_early got=%b exp=1", kif.key_down); end
        step(1);
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL release_down got=%b exp=0", kif.key_down); end
        step(15);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL release_pulses got=%0d exp=1", pulses); end
        checks++; if (kif.key_code !== 4'd9) begin errors++; $display("FAIL release_code got=%0d exp=9", kif.key_code); end
        checks++; if (col_bad) begin errors++; $display("FAIL hold_col_seq got=bad exp=rotating one-cold"); end
    endtask

    task automatic test_bounce();
        do_reset();
        frame(16'h0040); frame(16'h0040); frame(16'h0000);
        repeat (5) frame(16'h0040);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL bounce_pulses got=%0d exp=1", pulses); end
        checks++; if (last_pulse !== 97) begin errors++; $display("FAIL bounce_pulse_cycle got=%0d exp=97", last_pulse); end
        checks++; if (kif.key_code !== 4'd6) begin errors++; $display("FAIL bounce_code got=%0d exp=6", kif.key_code); end
    endtask

    task automatic test_multi();
        repeat (6) frame(16'h0021);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL multi_pulses got=%0d exp=1", pulses); end
        checks++; if (kif.key_down !== 1'b1) begin errors++; $display("FAIL multi_down got=%b exp=1", kif.key_down); end
        checks++; if (kif.key_code !== 4'd6) begin errors++; $display("FAIL multi_code got=%0d exp=6", kif.key_code); end
        repeat (4) frame(16'h0001);
        checks++; if (pulses !== 2) begin errors++; $display("FAIL change_pulses got=%0d exp=2", pulses); end
        checks++; if (last_pulse !== 273) begin errors++; $display("FAIL change_pulse_cycle got=%0d exp=273", last_pulse); end
        checks++; if (kif.key_code !== 4'd0) begin errors++; $display("FAIL change_code got=%0d exp=0", kif.key_code); end
        checks++; if (kif.key_down !== 1'b1) begin errors++; $display("FAIL change_down got=%b exp=1", kif.key_down); end
    endtask

    task automatic test_reset_mid();
        step(7);
        rst = 1'b1;
        #1;
        checks++; if (kif.key_col !== 4'b1110) begin errors++; $display("FAIL async_col got=%b exp=1110", kif.key_col); end
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL async_down got=%b exp=0", kif.key_down); end
        checks++; if (kif.key_code !== 4'd0) begin errors++; $display("FAIL async_code got=%0d exp=0", kif.key_code); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b exp=0", kif.key_valid); end
        pressed = '0;
        @(negedge clk);
        rst = 1'b0;
        k = 0; pulses = 0; last_pulse = -1; col_bad = 1'b0;
        step(3);
        checks++; if (kif.key_col !== 4'b1110) begin errors++; $display("FAIL restart_col3 got=%b exp=1110", kif.key_col); end
        step(1);
        checks++; if (kif.key_col !== 4'b1101) begin errors++; $display("FAIL restart_col4 got=%b exp=1101", kif.key_col); end
        step(60);
        checks++; if (pulses !== 0 || kif.key_down !== 1'b0) begin errors++; $display("FAIL restart_idle got pulses=%0d down=%b exp pulses=0 down=0", pulses, kif.key_down); end
        checks++; if (col_bad) begin errors++; $display("FAIL restart_col_seq got=bad exp=rotating one-cold"); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_idle();
        test_hold();
        test_release();
        test_bounce();
        test_multi();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
